s386_out_logger: RTL and testbench
==================================

# s386_out_logger

Downstream event logger for the s386 controller. It samples the controller's seven registered-state outputs (v13_D_6..v13_D_12) every clock and detects any change in the vector. Each change is stamped with a free-running cycle counter and buffered in a small FIFO, which a host or scoreboard drains over a valid/ready port. It sits directly after the s386 core, on the same clock and reset tree.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TS_W, 8: timestamp width in bits.
- blif_clk_net  in  1  clock; rising edge.
- blif_reset_net  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- ctl_in  in  7  controller output vector; bit i = v13_D_(6+i).
- log_en  in  1  enables event capture; sampling of ctl_in continues when low.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_data  out  TS_W+7  head entry {ts[TS_W-1:0], vec[6:0]}.
- fill  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky; set when an event was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- prev_q register: loads ctl_in every edge. Reset value 0.
- Change detect: chg = log_en & (ctl_in != prev_q), evaluated each cycle. Because prev_q resets to 0, a nonzero vector after reset logs one event.
- ts_q counter: increments every edge and wraps modulo 2^TS_W. Reset value 0. An event carries the ts_q value of the cycle in which chg is high.
- push = chg. pop = evt_valid & evt_ready.
- FIFO is first-word-fall-through. evt_valid = (fill != 0). evt_data shows the head entry. evt_data is 0 while empty and after reset.
- Full, push, no pop: the entry is dropped, fill stays DEPTH, and overflow sets.
- Full, push and pop together: both occur, fill stays DEPTH, overflow is not set.
- Empty with pop: impossible, because evt_valid is low.
- Push while empty: evt_valid is high from the next cycle. No bypass of the registered entry.
- ovf_clr together with a new drop: set wins.
- Reset assertion mid-operation: all state clears immediately and asynchronously. This includes fill=0, evt_valid=0, overflow=0, ts_q=0 and prev_q=0. FIFO contents are discarded.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. fill is tracked in its own counter and is not derived from the pointers.

## Timing
- Reset values: evt_valid 0, evt_data 0, fill 0, overflow 0.
- Latency from a ctl_in change sampled at edge k (with log_en high) to evt_valid: high after edge k when the FIFO was empty, which is 1 cycle.
- Handshake:
  - The consumer may hold evt_ready high continuously.
  - evt_data is stable while evt_valid is high and evt_ready is low.
  - The head advances on the edge where evt_valid & evt_ready.
- Throughput: one push and one pop per cycle.
- ctl_in must settle before the rising edge. s386 outputs are combinational from its DFFR state.
- No combinational path from evt_ready to evt_valid or evt_data.

## Structure
- Package s386_pkg holds:
  - localparam CTL_W = 7.
  - The evt_t struct {ts, vec}, parameterised through TS_W in the package.
- Sub-module s386_evt_fifo: generic FWFT FIFO with push, pop, full, empty, fill and a drop flag. The top contains only the change detect, the timestamp counter and the overflow logic.

## Test plan
1. Reset, then ctl_in=7'h00 held for 10 cycles → evt_valid stays 0, fill=0, ts_q reaches 10.
2. Reset, ctl_in=7'h05 from cycle 3, evt_ready=1 → exactly one event {ts=3, vec=7'h05}, evt_valid high for 1 cycle.
3. evt_ready=0, ctl_in toggles 7'h01/7'h02 every cycle for 6 cycles → fill=4 and overflow=1. The first 4 events are retained in order. Raise ovf_clr → overflow=0.
4. FIFO full, evt_ready=1, and a new change in the same cycle → fill stays 4, overflow stays 0, and the head advances.
5. log_en=0 during changes 7'h10→7'h11 → no events. Re-enable with ctl_in stable → no event. The next change logs.
6. Assert blif_reset_net low mid-cycle with fill=3 → evt_valid, fill and overflow drop to 0 immediately, before the next clock edge.
7. Run 300 cycles with one change every 50 cycles → logged ts values wrap correctly modulo 256.

Source files
------------

// File: rtl/s386_pkg.sv
// Shared widths and the logged-event record for the s386 output logger.
// Types only; no timing or flow control lives here.
package s386_pkg;
    localparam int CTL_W = 7;
    localparam int TS_W  = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [CTL_W-1:0] vec;
    } evt_t;
endpackage

// File: rtl/s386_evt_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter; head visible the cycle after push.
// A push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
module s386_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          wr_en, rd_en;

    always_comb begin
        full     = (fill_q == FW'(DEPTH));
        empty    = (fill_q == '0);
        rd_en    = pop & ~empty;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr_en    = push & (~full | rd_en);
        drop     = push & ~wr_en;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !rd_en) begin
            fill_d = fill_q + FW'(1);
        end else if (rd_en && !wr_en) begin
            fill_d = fill_q - FW'(1);
        end
        dout = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign fill = fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end
endmodule

// File: rtl/s386_out_logger.sv
// Timestamps every change of the s386 output vector and queues it; event visible 1 cycle after the change edge.
// Consumer drains over valid/ready; events arriving while full without a pop are dropped and latch overflow.
module s386_out_logger
    import s386_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                       blif_clk_net,
    input  logic                       blif_reset_net,
    input  logic [6:0]                 ctl_in,
    input  logic                       log_en,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [TS_W+6:0]            evt_data,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    logic [CTL_W-1:0] prev_q, prev_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             overflow_q, overflow_d;
    logic             chg, pop;
    logic             fifo_full, fifo_empty, fifo_drop;

    always_comb begin
        chg        = log_en & (ctl_in != prev_q);
        pop        = ~fifo_empty & evt_ready;
        prev_d     = ctl_in;
        ts_d       = ts_q + TS_W'(1);
        overflow_d = overflow_q;
        // A drop in the same cycle as a clear must leave the flag set.
        if (fifo_drop && fifo_full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    s386_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W + CTL_W)
    ) u_fifo (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .push  (chg),
        .pop   (pop),
        .din   ({ts_q, ctl_in}),
        .dout  (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill),
        .drop  (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;
    assign overflow  = overflow_q;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            prev_q     <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_s386_out_logger.sv
// Scoreboard bench for s386_out_logger: a queue model tracks expected events, fill and overflow.
module tb_s386_out_logger;
    import s386_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 8;

    logic          blif_clk_net = 1'b0;
    logic          blif_reset_net;
    logic [6:0]    ctl_in;
    logic          log_en;
    logic          evt_valid;
    logic          evt_ready;
    logic [TW+6:0] evt_data;
    logic [2:0]    fill;
    logic          overflow;
    logic          ovf_clr;

    int n_run  = 0;
    int n_fail = 0;

    evt_t       mq[$];
    logic [7:0] ts_m;
    logic [6:0] prev_m;
    logic       ovf_m;

    s386_out_logger #(.DEPTH(DEPTH), .TS_W(TW)) dut (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .ctl_in         (ctl_in),
        .log_en         (log_en),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .fill           (fill),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    always #5 blif_clk_net = ~blif_clk_net;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        evt_t head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check_eq("valid", 32'(evt_valid), 32'(mq.size() != 0));
        check_eq("fill", 32'(fill), 32'(mq.size()));
        check_eq("ovf", 32'(overflow), 32'(ovf_m));
        check_eq("data", 32'(evt_data), 32'(head));
    endtask

    task automatic model_clear();
        mq.delete();
        ts_m   = '0;
        prev_m = '0;
        ovf_m  = 1'b0;
    endtask

    // Advance one clock: update the model from the inputs present at the edge, then check.
    task automatic tick();
        logic pop_m, chg_m, drop_m;
        evt_t e;
        pop_m  = (mq.size() != 0) && evt_ready;
        chg_m  = log_en && (ctl_in != prev_m);
        e.ts   = ts_m;
        e.vec  = ctl_in;
        if (pop_m) begin
            check_eq("pop_head", 32'(evt_data), 32'(mq[0]));
            void'(mq.pop_front());
        end
        drop_m = chg_m && (mq.size() >= DEPTH);
        if (chg_m && !drop_m) mq.push_back(e);
        if (drop_m) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;
        prev_m = ctl_in;
        ts_m   = ts_m + 8'd1;
        @(posedge blif_clk_net);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        blif_reset_net = 1'b0;
        ctl_in    = '0;
        log_en    = 1'b1;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        #2;
        model_clear();
        check_outputs();
        @(negedge blif_clk_net);
        blif_reset_net = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Quiet vector after reset, then a change stamped with ts 10.
        do_reset();
        repeat (10) tick();
        ctl_in = 7'h01;
        repeat (3) tick();

        // Single change at cycle 3 with a consumer always ready.
        do_reset();
        repeat (3) tick();
        ctl_in = 7'h05;
        repeat (4) tick();

        // Fill and overflow with the consumer stalled, then clear the sticky flag.
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ctl_in = (i % 2 == 0) ? 7'h01 : 7'h02;
            tick();
        end
        check_eq("t3_fill", 32'(fill), 32'd4);
        check_eq("t3_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        check_eq("t3_clr", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        ctl_in    = 7'h03;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_eq("t4_fill", 32'(fill), 32'd4);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        tick();
        evt_ready = 1'b1;
        repeat (6) tick();

        // Capture disabled while the vector moves; re-enable on a stable vector.
        ctl_in = 7'h10;
        tick();
        log_en = 1'b0;
        ctl_in = 7'h11; tick();
        ctl_in = 7'h10; tick();
        ctl_in = 7'h11; tick();
        tick();
        log_en = 1'b1;
        repeat (2) tick();
        ctl_in = 7'h12;
        repeat (3) tick();

        // Asynchronous reset mid-cycle with three entries held and overflow set.
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ctl_in = (i % 2 == 0) ? 7'h21 : 7'h22;
            tick();
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_eq("t6_fill", 32'(fill), 32'd3);
        check_eq("t6_ovf", 32'(overflow), 32'd1);
        #3;
        blif_reset_net = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(evt_valid), 32'd0);
        check_eq("t6_rst_fill", 32'(fill), 32'd0);
        check_eq("t6_rst_ovf", 32'(overflow), 32'd0);
        check_eq("t6_rst_data", 32'(evt_data), 32'd0);
        model_clear();
        ctl_in    = '0;
        evt_ready = 1'b1;
        #2;
        blif_reset_net = 1'b1;

        // Long run so timestamps wrap past 255.
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 10) ctl_in = ctl_in ^ 7'h40;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
